// File: rtl/arm_pipe_pkg.sv
// -----------------------------------------------------------------------------
// arm_pipe_pkg
// Shared definitions for the 5-stage ARM-subset pipeline.
//   ADDR_W / INST_W : default address and instruction widths
//   NOP_INST        : encoding used for flushed or substituted instructions
//   PC_STEP         : byte increment between sequential fetches
//   fetch_state_t   : fetch control states (RUN, REDIRECT)
//   if_id_t         : IF/ID pipeline register contents, also used by decode
// -----------------------------------------------------------------------------
package arm_pipe_pkg;

   localparam int ADDR_W = 32;
   localparam int INST_W = 32;

   localparam logic [INST_W-1:0] NOP_INST = '0;
   localparam int                PC_STEP  = 4;

   typedef enum logic [0:0] {
      RUN      = 1'b0,
      REDIRECT = 1'b1
   } fetch_state_t;

   typedef struct packed {
      logic [ADDR_W-1:0] pc;
      logic [INST_W-1:0] inst;
      logic              valid;
   } if_id_t;

endpackage

// File: rtl/pc_register.sv
// -----------------------------------------------------------------------------
// pc_register
// Generic load-enabled register with synchronous active-low reset.
// Ports:
//   clk     in   rising-edge clock
//   rst     in   synchronous active-low reset, loads RESET_VAL
//   load_i  in   capture d_i on this edge
//   d_i     in   next value
//   q_o     out  registered value
// -----------------------------------------------------------------------------
module pc_register #(
   parameter int               WIDTH     = 32,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_i,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   // Reset takes priority; otherwise the value only moves when loaded.
   always_ff @(posedge clk) begin
      if (!rst) begin
         q_o <= RESET_VAL;
      end else if (load_i) begin
         q_o <= d_i;
      end
   end

endmodule

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
// IF stage: owns the PC, drives the combinational instruction memory and
// captures the returned word into the IF/ID register. Handles hazard freeze,
// EX-stage branch redirect with flush, and NOP substitution for fetches past
// the populated memory (reported through the sticky fetch_fault).
//
// Optional build macro FETCH_PERF_CNT_EN adds saturating 32-bit counters
// perf_fetched, perf_stalls and perf_flushes.
//
// Ports:
//   clk           in   rising-edge clock
//   rst           in   synchronous active-low reset
//   freeze        in   hazard stall, holds PC and IF/ID
//   branch_taken  in   redirect request from EX
//   branch_addr   in   redirect target, low two bits ignored
//   imem_addr     out  fetch address (= PC, combinational)
//   imem_inst     in   instruction word for imem_addr
//   pc_id         out  IF/ID fetched PC + 4
//   inst_id       out  IF/ID fetched instruction
//   valid_id      out  IF/ID holds a real instruction
//   perf_*        out  performance counters (FETCH_PERF_CNT_EN only)
//   fetch_fault   out  sticky out-of-range fetch flag
// -----------------------------------------------------------------------------
module fetch_stage #(
   parameter int                ADDR_W    = 32,
   parameter int                INST_W    = 32,
   parameter logic [ADDR_W-1:0] RESET_PC  = '0,
   parameter int                MEM_DEPTH = 49
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              freeze,
   input  logic              branch_taken,
   input  logic [ADDR_W-1:0] branch_addr,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic [INST_W-1:0] imem_inst,
   output logic [ADDR_W-1:0] pc_id,
   output logic [INST_W-1:0] inst_id,
   output logic              valid_id,
`ifdef FETCH_PERF_CNT_EN
   output logic [31:0]       perf_fetched,
   output logic [31:0]       perf_stalls,
   output logic [31:0]       perf_flushes,
`endif
   output logic              fetch_fault
);

   import arm_pipe_pkg::*;

   logic [ADDR_W-1:0] pc_q;
   logic [ADDR_W-1:0] pc_d;
   logic [ADDR_W-1:0] pcPlus4;
   logic              pcLoad;
   logic              inRange;
   logic              advance;

   fetch_state_t      state_q, state_d;
   logic [ADDR_W-1:0] pcId_q, pcId_d;
   logic [INST_W-1:0] instId_q, instId_d;
   logic              validId_q, validId_d;
   logic              fault_q, fault_d;

   // The PC moves on a branch even under freeze; it only holds on a plain stall.
   always_comb begin
      pcPlus4 = pc_q + ADDR_W'(PC_STEP);
      pcLoad  = branch_taken | ~freeze;
      advance = ~branch_taken & ~freeze;
      inRange = ({2'b00, pc_q[ADDR_W-1:2]} < ADDR_W'(MEM_DEPTH));
      if (branch_taken) begin
         pc_d = {branch_addr[ADDR_W-1:2], 2'b00};
      end else begin
         pc_d = pcPlus4;
      end
   end

   pc_register #(
      .WIDTH     (ADDR_W),
      .RESET_VAL (RESET_PC)
   ) u_pc (
      .clk    (clk),
      .rst    (rst),
      .load_i (pcLoad),
      .d_i    (pc_d),
      .q_o    (pc_q)
   );

   assign imem_addr = pc_q;

   // IF/ID next state: branch flushes, freeze holds, otherwise capture the
   // fetched word (or a NOP plus fault when the PC is past populated memory).
   // In REDIRECT the held bubble is forced invalid so a frozen flush can
   // never surface as a real instruction.
   always_comb begin
      state_d   = state_q;
      pcId_d    = pcId_q;
      instId_d  = instId_q;
      validId_d = validId_q;
      fault_d   = fault_q;
      if (branch_taken) begin
         state_d   = REDIRECT;
         pcId_d    = '0;
         instId_d  = INST_W'(NOP_INST);
         validId_d = 1'b0;
      end else if (freeze) begin
         if (state_q == REDIRECT) begin
            validId_d = 1'b0;
         end
      end else begin
         state_d = RUN;
         pcId_d  = pcPlus4;
         if (inRange) begin
            instId_d  = imem_inst;
            validId_d = 1'b1;
         end else begin
            instId_d  = INST_W'(NOP_INST);
            validId_d = 1'b0;
            fault_d   = 1'b1;
         end
      end
   end

   // IF/ID and control state registers; reset discards any pending event.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= RUN;
         pcId_q    <= '0;
         instId_q  <= '0;
         validId_q <= 1'b0;
         fault_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         pcId_q    <= pcId_d;
         instId_q  <= instId_d;
         validId_q <= validId_d;
         fault_q   <= fault_d;
      end
   end

   assign pc_id       = pcId_q;
   assign inst_id     = instId_q;
   assign valid_id    = validId_q;
   assign fetch_fault = fault_q;

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] fetchedCnt_q;
   logic [31:0] stallCnt_q;
   logic [31:0] flushCnt_q;

   // Saturating event counters: fetched = valid written 1, stall = freeze
   // hold edge, flush = branch edge.
   always_ff @(posedge clk) begin
      if (!rst) begin
         fetchedCnt_q <= '0;
         stallCnt_q   <= '0;
         flushCnt_q   <= '0;
      end else begin
         if (advance && inRange && (fetchedCnt_q != '1)) begin
            fetchedCnt_q <= fetchedCnt_q + 32'd1;
         end
         if (freeze && !branch_taken && (stallCnt_q != '1)) begin
            stallCnt_q <= stallCnt_q + 32'd1;
         end
         if (branch_taken && (flushCnt_q != '1)) begin
            flushCnt_q <= flushCnt_q + 32'd1;
         end
      end
   end

   assign perf_fetched = fetchedCnt_q;
   assign perf_stalls  = stallCnt_q;
   assign perf_flushes = flushCnt_q;
`else
   logic unusedAdvance;
   assign unusedAdvance = advance;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
// Directed scoreboard bench for fetch_stage. Each stimulus step pushes the
// expected post-edge outputs into a queue; a monitor pops and compares on the
// falling edge. The instruction memory model returns a junk word past the
// populated range so NOP substitution is observable.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        freeze;
   logic        branch_taken;
   logic [31:0] branch_addr;
   logic [31:0] imem_addr;
   logic [31:0] imem_inst;
   logic [31:0] pc_id;
   logic [31:0] inst_id;
   logic        valid_id;
   logic        fetch_fault;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] perf_fetched;
   logic [31:0] perf_stalls;
   logic [31:0] perf_flushes;
`endif

   int checks = 0;
   int passes = 0;

   typedef struct {
      string       name;
      logic [31:0] addr;
      logic [31:0] pc;
      logic [31:0] inst;
      logic        valid;
      logic        fault;
   } exp_t;

   exp_t expQ[$];

   always #5 clk = ~clk;

   fetch_stage #(
      .ADDR_W    (32),
      .INST_W    (32),
      .RESET_PC  (32'h0),
      .MEM_DEPTH (49)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .freeze       (freeze),
      .branch_taken (branch_taken),
      .branch_addr  (branch_addr),
      .imem_addr    (imem_addr),
      .imem_inst    (imem_inst),
      .pc_id        (pc_id),
      .inst_id      (inst_id),
      .valid_id     (valid_id),
`ifdef FETCH_PERF_CNT_EN
      .perf_fetched (perf_fetched),
      .perf_stalls  (perf_stalls),
      .perf_flushes (perf_flushes),
`endif
      .fetch_fault  (fetch_fault)
   );

   // Memory contents: word 0 is the documented MOV, the rest are ADD r0,#k.
   function automatic logic [31:0] memWord(input int k);
      if (k == 0) return 32'hE3A00014;
      return 32'hE2800000 | 32'(k);
   endfunction

   // Combinational instruction memory; junk beyond the populated words.
   always_comb begin
      if (imem_addr[31:2] < 30'd49) imem_inst = memWord(int'(imem_addr[31:2]));
      else                          imem_inst = 32'hDEADBEEF;
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
   endtask

   // Drive one edge's inputs and queue the outputs expected after that edge.
   task automatic applyStimulus(input string name, input logic r, input logic f, input logic b,
                                input logic [31:0] ba, input logic [31:0] eA, input logic [31:0] eP,
                                input logic [31:0] eI, input logic eV, input logic eF);
      exp_t e;
      rst          = r;
      freeze       = f;
      branch_taken = b;
      branch_addr  = ba;
      @(posedge clk);
      #1;
      e.name  = name;
      e.addr  = eA;
      e.pc    = eP;
      e.inst  = eI;
      e.valid = eV;
      e.fault = eF;
      expQ.push_back(e);
   endtask

   // Monitor: compare the oldest expectation on each falling edge.
   always @(negedge clk) begin
      exp_t e;
      if (expQ.size() > 0) begin
         e = expQ.pop_front();
         checkOutput({e.name, " imem_addr"}, imem_addr, e.addr);
         checkOutput({e.name, " pc_id"}, pc_id, e.pc);
         checkOutput({e.name, " inst_id"}, inst_id, e.inst);
         checkOutput({e.name, " valid_id"}, {31'd0, valid_id}, {31'd0, e.valid});
         checkOutput({e.name, " fetch_fault"}, {31'd0, fetch_fault}, {31'd0, e.fault});
      end
   end

   // Watchdog so the run always ends.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      rst = 1'b0; freeze = 1'b0; branch_taken = 1'b0; branch_addr = '0;

      applyStimulus("reset", 0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0);

      for (int k = 0; k < 4; k++)
         applyStimulus("run", 1, 0, 0, 32'h0, 32'(4*(k+1)), 32'(4*(k+1)), memWord(k), 1, 0);

      for (int k = 0; k < 3; k++)
         applyStimulus("freeze", 1, 1, 0, 32'h0, 32'h10, 32'h10, memWord(3), 1, 0);

      applyStimulus("release", 1, 0, 0, 32'h0, 32'h14, 32'h14, memWord(4), 1, 0);
      applyStimulus("run14", 1, 0, 0, 32'h0, 32'h18, 32'h18, memWord(5), 1, 0);

      applyStimulus("brFreeze", 1, 1, 1, 32'h73, 32'h70, 32'h0, 32'h0, 0, 0);
      applyStimulus("redirFrz", 1, 1, 0, 32'h0, 32'h70, 32'h0, 32'h0, 0, 0);
      applyStimulus("afterBr", 1, 0, 0, 32'h0, 32'h74, 32'h74, memWord(28), 1, 0);

      for (int k = 29; k < 49; k++)
         applyStimulus("runHigh", 1, 0, 0, 32'h0, 32'(4*(k+1)), 32'(4*(k+1)), memWord(k), 1, 0);

      applyStimulus("word49", 1, 0, 0, 32'h0, 32'hC8, 32'hC8, 32'h0, 0, 1);
      applyStimulus("word50", 1, 0, 0, 32'h0, 32'hCC, 32'hCC, 32'h0, 0, 1);
      applyStimulus("brZero", 1, 0, 1, 32'h0, 32'h0, 32'h0, 32'h0, 0, 1);
      applyStimulus("faultSticky", 1, 0, 0, 32'h0, 32'h4, 32'h4, memWord(0), 1, 1);

      applyStimulus("brTop", 1, 0, 1, 32'hFFFFFFFE, 32'hFFFFFFFC, 32'h0, 32'h0, 0, 1);
      applyStimulus("wrap", 1, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 1);
      applyStimulus("afterWrap", 1, 0, 0, 32'h0, 32'h4, 32'h4, memWord(0), 1, 1);

      applyStimulus("resetAll", 0, 1, 1, 32'h40, 32'h0, 32'h0, 32'h0, 0, 0);
`ifdef FETCH_PERF_CNT_EN
      checkOutput("perf_fetched", perf_fetched, 32'h0);
      checkOutput("perf_stalls", perf_stalls, 32'h0);
      checkOutput("perf_flushes", perf_flushes, 32'h0);
`endif
      applyStimulus("postReset", 1, 0, 0, 32'h0, 32'h4, 32'h4, memWord(0), 1, 0);

      @(negedge clk);
      @(negedge clk);
      checkOutput("queueDrained", 32'(expQ.size()), 32'h0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
IF stage of the 5-stage ARM-subset pipeline.
- Owns the program counter and drives the fetch address to the combinational instruction memory.
- Captures the returned word into the IF/ID pipeline register.
- Applies hazard-unit freeze and EX-stage branch redirect/flush.
- Substitutes a NOP for fetches beyond the populated memory range.

Parameters:
ADDR_W, 32, PC and address width
INST_W, 32, instruction width
RESET_PC, 0, PC value loaded on reset
MEM_DEPTH, 49, populated instruction-memory words; word index >= MEM_DEPTH is out of range

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous, active-low reset
freeze  in  1  hazard-unit stall: hold PC and IF/ID
branch_taken  in  1  EX-stage redirect request
branch_addr  in  ADDR_W  redirect target (byte address)
imem_addr  out  ADDR_W  fetch address to instruction memory (= PC, combinational)
imem_inst  in  INST_W  instruction word returned combinationally for imem_addr
pc_id  out  ADDR_W  IF/ID: fetched PC + 4
inst_id  out  INST_W  IF/ID: fetched instruction
valid_id  out  1  IF/ID: inst_id is a real fetched instruction
fetch_fault  out  1  sticky: an out-of-range fetch was captured

Behaviour:
- Reset (rst==0 at a clk edge) forces:
  - PC <= RESET_PC.
  - pc_id, inst_id, valid_id, fetch_fault <= 0.
  - Reset overrides every other input. Reset mid-stall or mid-branch discards the pending event.
- imem_addr = PC, driven continuously with no register delay.
- Next-state priority each edge: reset > branch_taken > freeze > advance.
- branch_taken==1, regardless of freeze:
  - PC <= {branch_addr[ADDR_W-1:2], 2'b00}; low two bits are silently forced to 0.
  - IF/ID flushed: pc_id <= 0, inst_id <= 0 (NOP), valid_id <= 0.
- freeze==1 and branch_taken==0:
  - PC, pc_id, inst_id, valid_id hold.
  - A freeze lasting N cycles holds all state for exactly N edges.
- Advance (freeze==0, branch_taken==0):
  - PC <= PC + 4, modulo 2^ADDR_W; wrap at all-ones is not an error.
  - pc_id <= PC + 4.
  - In range (PC[ADDR_W-1:2] < MEM_DEPTH): inst_id <= imem_inst, valid_id <= 1.
  - Out of range: inst_id <= 0, valid_id <= 0, fetch_fault <= 1. PC still advances.
- fetch_fault clears only on reset.
- Latency: instruction at PC appears on inst_id one edge after PC is presented, when not frozen.
- Branch redirect penalty: one flushed bubble from this stage. Older-stage flushing belongs to the other stage registers.
- Simultaneous freeze and branch_taken: branch wins and the flush is applied. The hazard unit must not re-freeze the bubble.
- Control FSM, two states:
  - RUN: normal operation.
  - REDIRECT: entered on the edge that takes a branch. Returns to RUN on the next unfrozen edge.
  - While in REDIRECT, valid_id stays 0 even under freeze, so a frozen bubble is never mistaken for an instruction.

Optional Feature:
FETCH_PERF_CNT_EN
- Defined: adds three 32-bit outputs, saturating at all-ones, all reset to 0:
  - perf_fetched: counts edges where valid_id is written 1.
  - perf_stalls: counts freeze-hold edges.
  - perf_flushes: counts branch-taken edges.
- Undefined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package arm_pipe_pkg holds:
  - Constants NOP_INST = 0, PC_STEP = 4, ADDR_W, INST_W.
  - fetch_state_t enum {RUN, REDIRECT}.
  - Struct if_id_t {pc, inst, valid}, reused by the decode stage.
- One natural sub-module: pc_register, a generic ADDR_W register with load-enable and synchronous active-low reset to RESET_PC. The IF/ID register stays inline.

Test Plan:
1. Reset then release with mem[0]=0xE3A00014: cycle 0 imem_addr=0x0. After the first edge: inst_id=0xE3A00014, pc_id=0x4, valid_id=1, imem_addr=0x4.
2. Free-run 5 edges from reset: pc_id sequence 0x4, 0x8, 0xC, 0x10, 0x14; imem_addr=0x14.
3. freeze=1 for 3 edges with PC=0x10: imem_addr stays 0x10 and IF/ID unchanged. After release, the next edge gives pc_id=0x14, inst_id=mem[4].
4. branch_taken=1, branch_addr=0x73 while freeze=1: next edge PC=0x70, inst_id=0, valid_id=0. The following unfrozen edge gives pc_id=0x74, inst_id=mem[28], valid_id=1.
5. Run to PC=0xC4 (word 49): captured inst_id=0, valid_id=0, fetch_fault=1. fetch_fault stays 1 after a branch back to 0x0 and clears only on rst=0.
6. rst=0 asserted together with branch_taken=1 and freeze=1: after the edge PC=RESET_PC and all IF/ID outputs are 0. With FETCH_PERF_CNT_EN defined, all counters are 0.
